// File: rtl/map_sequencer.sv
// map_sequencer: walks the subcarrier map RAM for one OFDM symbol and
// presents each entry (index + type code) on a valid/ready interface
// through a 2-entry skid buffer.
// Optional build macro MAP_SEQ_STATS_EN adds n_data / n_pilot counters.
module map_sequencer #(
  parameter int DEPHT_RAM = 10,
  parameter int FFTSIZE   = 1024,
  parameter int NUM_BW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2:0]           bw_sel,
  input  logic                 abort,
  output logic                 busy,
  output logic [DEPHT_RAM-1:0] map_addr,
  output logic [2:0]           map_bw,
  input  logic [1:0]           map_dat,
  output logic                 sc_valid,
  input  logic                 sc_ready,
  output logic [DEPHT_RAM-1:0] sc_idx,
  output logic [1:0]           sc_type,
  output logic                 sc_last,
  output logic                 done,
  output logic                 err_bw
`ifdef MAP_SEQ_STATS_EN
  ,
  output logic [DEPHT_RAM:0]   n_data,
  output logic [DEPHT_RAM:0]   n_pilot
`endif
);

  localparam logic [DEPHT_RAM-1:0] LAST      = DEPHT_RAM'(FFTSIZE - 1);
  localparam logic [31:0]          NUM_BW_U  = 32'(NUM_BW);

  typedef enum logic [2:0] {IDLE, PRIME, RUN, DRAIN, DONE} state_t;

  state_t               state;

  // Address issued last cycle; its RAM data is on map_dat this cycle
  logic                 pend_vld;
  logic [DEPHT_RAM-1:0] pend_idx;

  // Second skid slot (the head slot is the sc_* output register set)
  logic                 b_vld;
  logic [DEPHT_RAM-1:0] b_idx;
  logic [1:0]           b_type;
  logic                 b_last;

  logic                 pop;
  logic                 flush;
  logic                 issue;
  logic                 addr_last;
  logic                 bw_legal;
  logic                 go;
  logic [1:0]           occ;

  // Handshake, credit and start qualification
  always_comb begin
    pop       = sc_valid & sc_ready;
    flush     = abort & (state != IDLE);
    bw_legal  = ({29'd0, bw_sel} < NUM_BW_U);
    go        = (state == IDLE) & start & ~abort;
    addr_last = (map_addr == LAST);
    // Occupancy at the end of this cycle; issuing is safe only if the data
    // arriving next cycle has a free slot even if nothing is popped then.
    occ       = {1'b0, sc_valid} + {1'b0, b_vld} + {1'b0, pend_vld} - {1'b0, pop};
    issue     = ~flush & ((state == PRIME) | ((state == RUN) & (occ <= 2'd1)));
  end

  // Control FSM: state, address generator and registered status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_bw   <= 1'b0;
      map_addr <= '0;
      map_bw   <= '0;
    end else begin
      done   <= 1'b0;
      err_bw <= 1'b0;
      if (flush) begin
        state    <= IDLE;
        busy     <= 1'b0;
        map_addr <= '0;
      end else begin
        if (issue && !addr_last)
          map_addr <= map_addr + DEPHT_RAM'(1);
        case (state)
          IDLE: begin
            if (go) begin
              if (bw_legal) begin
                map_bw   <= bw_sel;
                map_addr <= '0;
                state    <= PRIME;
                busy     <= 1'b1;
              end else begin
                err_bw <= 1'b1;
              end
            end
          end
          PRIME: state <= addr_last ? DRAIN : RUN;
          RUN: begin
            if (issue && addr_last)
              state <= DRAIN;
          end
          DRAIN: begin
            if (pop && sc_last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Read tagging and 2-entry skid buffer; head slot drives sc_* directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld <= 1'b0;
      pend_idx <= '0;
      sc_valid <= 1'b0;
      sc_idx   <= '0;
      sc_type  <= '0;
      sc_last  <= 1'b0;
      b_vld    <= 1'b0;
      b_idx    <= '0;
      b_type   <= '0;
      b_last   <= 1'b0;
    end else if (flush) begin
      pend_vld <= 1'b0;
      sc_valid <= 1'b0;
      b_vld    <= 1'b0;
    end else begin
      pend_vld <= issue;
      if (issue)
        pend_idx <= map_addr;
      if (pop) begin
        // Head leaves: slot B (if any) moves up, new capture fills behind it
        if (b_vld) begin
          sc_idx   <= b_idx;
          sc_type  <= b_type;
          sc_last  <= b_last;
          b_vld    <= pend_vld;
          if (pend_vld) begin
            b_idx  <= pend_idx;
            b_type <= map_dat;
            b_last <= (pend_idx == LAST);
          end
        end else begin
          sc_valid <= pend_vld;
          if (pend_vld) begin
            sc_idx  <= pend_idx;
            sc_type <= map_dat;
            sc_last <= (pend_idx == LAST);
          end
        end
      end else if (pend_vld) begin
        if (!sc_valid) begin
          sc_valid <= 1'b1;
          sc_idx   <= pend_idx;
          sc_type  <= map_dat;
          sc_last  <= (pend_idx == LAST);
        end else begin
          b_vld  <= 1'b1;
          b_idx  <= pend_idx;
          b_type <= map_dat;
          b_last <= (pend_idx == LAST);
        end
      end
    end
  end

`ifdef MAP_SEQ_STATS_EN
  // Saturating counts of accepted data / pilot entries, cleared on start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_data  <= '0;
      n_pilot <= '0;
    end else if (go && bw_legal) begin
      n_data  <= '0;
      n_pilot <= '0;
    end else if (pop) begin
      if (sc_type == 2'b01 && n_data != '1)
        n_data <= n_data + (DEPHT_RAM+1)'(1);
      if (sc_type == 2'b10 && n_pilot != '1)
        n_pilot <= n_pilot + (DEPHT_RAM+1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_map_sequencer.sv
// Table-driven bench for map_sequencer with a behavioural map RAM
// (one-cycle read latency, per-profile contents).
module tb_map_sequencer;

  localparam int DW  = 4;
  localparam int FFT = 16;
  localparam int NBW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2:0]    bw_sel = '0;
  logic          abort = 1'b0;
  logic          busy;
  logic [DW-1:0] map_addr;
  logic [2:0]    map_bw;
  logic [1:0]    map_dat = '0;
  logic          sc_valid;
  logic          sc_ready = 1'b0;
  logic [DW-1:0] sc_idx;
  logic [1:0]    sc_type;
  logic          sc_last;
  logic          done;
  logic          err_bw;
`ifdef MAP_SEQ_STATS_EN
  logic [DW:0]   n_data;
  logic [DW:0]   n_pilot;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  map_sequencer #(.DEPHT_RAM(DW), .FFTSIZE(FFT), .NUM_BW(NBW)) dut (
    .clk(clk), .rst(rst), .start(start), .bw_sel(bw_sel), .abort(abort),
    .busy(busy), .map_addr(map_addr), .map_bw(map_bw), .map_dat(map_dat),
    .sc_valid(sc_valid), .sc_ready(sc_ready), .sc_idx(sc_idx),
    .sc_type(sc_type), .sc_last(sc_last), .done(done), .err_bw(err_bw)
`ifdef MAP_SEQ_STATS_EN
    , .n_data(n_data), .n_pilot(n_pilot)
`endif
  );

  always #5 clk = ~clk;

  // Map contents per profile
  function automatic logic [1:0] map_code(input logic [2:0] bw, input logic [3:0] a);
    case (bw)
      3'd0:    map_code = 2'b01;
      3'd1:    map_code = 2'b10;
      3'd2:    map_code = a[1:0];
      default: map_code = a[1:0] ^ bw[1:0];
    endcase
  endfunction

  always @(posedge clk) map_dat <= map_code(map_bw, map_addr);

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [2:0] bw;
    logic [3:0] rdy;          // sc_ready pattern indexed by cycle % 4
    int         abort_at;     // sc_idx at which to abort, -1 none
    bit         start_in_done;
    int         exp_n;        // accepted entries
    int         exp_done;
    int         exp_err;
    int         exp_first;    // cycle of first sc_valid, -1 none
    int         exp_done_cyc; // -1 unchecked
    int         exp_ndata;    // -1 unchecked
    int         exp_npilot;
  } vec_t;

  vec_t tbl[8];

  task automatic run_vec(input vec_t v, input int id);
    int  nacc = 0, ndone = 0, nerr = 0, first = -1, done_cyc = -1;
    int  busy_seen = 0, post_busy = 0, valid_seen = 0;
    int  aborted = 0, abort_cyc = -1;
    bit  prev_stall = 0;
    logic [7:0] prev = '0;
    @(negedge clk);
    start  = 1'b1;
    bw_sel = v.bw;
    for (int cyc = 1; cyc <= 80; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      abort = 1'b0;
      if (prev_stall)
        chk($sformatf("v%0d stall_hold", id), {sc_valid, sc_idx, sc_type, sc_last}, prev);
      if (busy) busy_seen++;
      if (sc_valid) valid_seen++;
      if (sc_valid && first < 0) first = cyc;
      if (err_bw) nerr++;
      if (done_cyc > 0 && busy) post_busy++;
      if (done) begin
        ndone++;
        done_cyc = cyc;
        if (v.start_in_done) begin
          start  = 1'b1;
          bw_sel = 3'd0;
        end
      end
      if (aborted && cyc == abort_cyc + 1)
        chk($sformatf("v%0d abort_drop", id), {sc_valid, busy}, 0);
      sc_ready = v.rdy[cyc % 4];
      if (!aborted && v.abort_at >= 0 && sc_valid && int'(sc_idx) == v.abort_at) begin
        abort     = 1'b1;
        sc_ready  = 1'b0;
        aborted   = 1;
        abort_cyc = cyc;
      end
      prev_stall = sc_valid && !sc_ready && !abort;
      prev       = {sc_valid, sc_idx, sc_type, sc_last};
      if (sc_valid && sc_ready) begin
        chk($sformatf("v%0d idx", id), int'(sc_idx), nacc);
        chk($sformatf("v%0d type@%0d", id, nacc), int'(sc_type), int'(map_code(v.bw, 4'(nacc))));
        chk($sformatf("v%0d last@%0d", id, nacc), int'(sc_last), int'(nacc == FFT - 1));
        nacc++;
      end
    end
    abort    = 1'b0;
    sc_ready = 1'b0;
    chk($sformatf("v%0d entries", id), nacc, v.exp_n);
    chk($sformatf("v%0d done_count", id), ndone, v.exp_done);
    chk($sformatf("v%0d err_count", id), nerr, v.exp_err);
    chk($sformatf("v%0d first_valid", id), first, v.exp_first);
    chk($sformatf("v%0d busy_after_done", id), post_busy, 0);
    if (v.exp_done_cyc >= 0)
      chk($sformatf("v%0d done_cycle", id), done_cyc, v.exp_done_cyc);
    if (v.exp_err != 0)
      chk($sformatf("v%0d err_quiet", id), busy_seen + valid_seen, 0);
`ifdef MAP_SEQ_STATS_EN
    if (v.exp_ndata >= 0) begin
      chk($sformatf("v%0d n_data", id), int'(n_data), v.exp_ndata);
      chk($sformatf("v%0d n_pilot", id), int'(n_pilot), v.exp_npilot);
    end
`endif
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {busy, sc_valid, sc_idx, sc_type, sc_last, done, err_bw, map_addr, map_bw}, 0);
  endtask

  initial begin
    //          bw    rdy      abrt sid  n   dn er 1st dcy nd  np
    tbl[0] = '{3'd0, 4'b1111, -1, 1'b0, 16, 1, 0, 3, 19, 16, 0};
    tbl[1] = '{3'd0, 4'b1001, -1, 1'b0, 16, 1, 0, 3, -1, 16, 0};
    tbl[2] = '{3'd2, 4'b1111, -1, 1'b0, 16, 1, 0, 3, 19, 4,  4};
    tbl[3] = '{3'd6, 4'b1111, -1, 1'b0, 0,  0, 1, -1, -1, -1, -1};
    tbl[4] = '{3'd7, 4'b1111, -1, 1'b0, 0,  0, 1, -1, -1, -1, -1};
    tbl[5] = '{3'd1, 4'b1111,  7, 1'b0, 7,  0, 0, 3, -1, -1, -1};
    tbl[6] = '{3'd1, 4'b1111, -1, 1'b0, 16, 1, 0, 3, 19, 0,  16};
    tbl[7] = '{3'd0, 4'b1111, -1, 1'b1, 16, 1, 0, 3, 19, 16, 0};

    #12;
    chk_all_zero("reset_state");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_reset_idle");

    for (int i = 0; i < 8; i++) run_vec(tbl[i], i);

    // start and abort together in IDLE: nothing happens
    begin
      int act = 0;
      @(negedge clk);
      start = 1'b1; abort = 1'b1; bw_sel = 3'd0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        act += int'(busy) + int'(sc_valid) + int'(err_bw) + int'(done);
      end
      chk("start_abort_idle", act, 0);
    end

    // asynchronous reset mid-RUN, then a full symbol from scratch
    begin
      int k = 0;
      @(negedge clk);
      start = 1'b1; bw_sel = 3'd2; sc_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!(sc_valid && sc_idx == 4'd5) && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("reach_idx5", k < 40 ? 1 : 0, 1);
      #2 rst = 1'b1;
      #1 chk_all_zero("async_reset_mid_run");
      sc_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_vec(tbl[0], 8);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/map_sequencer.md
MAP_SEQUENCER -- requirements
Module: map_sequencer

Interface
REQ-001 The block SHALL have parameter DEPHT_RAM, default 10, meaning the map RAM address width.
REQ-002 The block SHALL have parameter FFTSIZE, default 1024, meaning the number of subcarriers per symbol (at most 2^DEPHT_RAM).
REQ-003 The block SHALL have parameter NUM_BW, default 6, meaning the number of bandwidth profiles; legal index_bw values are 0..NUM_BW-1.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all logic is clocked on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port start, input, 1 bit: single-cycle request to sequence one symbol.
REQ-007 The block SHALL have port bw_sel, input, 3 bits: bandwidth profile, sampled on the start cycle.
REQ-008 The block SHALL have port abort, input, 1 bit: terminates the current symbol.
REQ-009 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 The block SHALL have port map_addr, output, DEPHT_RAM bits: map RAM address.
REQ-011 The block SHALL have port map_bw, output, 3 bits: the latched profile, driven to the RAM index_bw input.
REQ-012 The block SHALL have port map_dat, input, 2 bits: RAM code, valid one clk after map_addr.
REQ-013 The block SHALL have port sc_valid, output, 1 bit, and port sc_ready, input, 1 bit: downstream valid/ready handshake.
REQ-014 The block SHALL have port sc_idx, output, DEPHT_RAM bits: subcarrier index of the presented entry.
REQ-015 The block SHALL have port sc_type, output, 2 bits: the map code, passed through unchanged (00 null, 01 data, 10 pilot, 11 reserved).
REQ-016 The block SHALL have port sc_last, output, 1 bit: high when sc_idx equals FFTSIZE-1.
REQ-017 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of a symbol.
REQ-018 The block SHALL have port err_bw, output, 1 bit: one-cycle pulse when start arrives with bw_sel >= NUM_BW.

Function
REQ-019 The state machine SHALL use the states IDLE, PRIME, RUN, DRAIN and DONE.
REQ-020 In IDLE, start with a legal bw_sel SHALL latch map_bw, set map_addr to 0 and move to PRIME.
REQ-021 In IDLE, start with an illegal bw_sel SHALL pulse err_bw and remain in IDLE.
REQ-022 In PRIME, the block SHALL wait one cycle to cover the RAM read latency and then enter RUN.
REQ-023 In RUN, map_addr SHALL increment by 1 on each cycle in which the 2-entry skid buffer will not overflow.
REQ-024 map_addr SHALL stop at FFTSIZE-1 and never wrap.
REQ-025 Each map_dat SHALL be captured into the skid buffer tagged with the address that produced it.
REQ-026 Every index 0..FFTSIZE-1 SHALL be presented exactly once, in ascending order, under any sc_ready pattern, with no drops and no duplicates.
REQ-027 While sc_valid=1 and sc_ready=0, sc_idx, sc_type and sc_last SHALL remain stable.
REQ-028 After the last address is issued, the block SHALL move to DRAIN; when the entry with sc_last=1 is accepted, it SHALL move to DONE.
REQ-029 DONE SHALL pulse done for one cycle and then return to IDLE.
REQ-030 start SHALL be ignored in every state except IDLE, and start in the DONE cycle SHALL be ignored.
REQ-031 abort in any non-IDLE state SHALL flush the skid buffer, drop sc_valid on the next cycle, return to IDLE and not pulse done.
REQ-032 When start and abort are both high in IDLE, abort SHALL win and no symbol SHALL start.
REQ-033 Latency from start to the first sc_valid SHALL be 3 cycles.
REQ-034 With sc_ready held at 1, the block SHALL sustain one entry per cycle, and done SHALL occur FFTSIZE+3 cycles after start.

Reset
REQ-035 Asserting rst SHALL immediately force state IDLE, map_addr 0, map_bw 0, skid buffer empty, and busy, sc_valid, sc_idx, sc_type, sc_last, done and err_bw all 0.
REQ-036 Reset applied mid-symbol SHALL discard that symbol, and the first start after release SHALL behave as from power-up.

Configuration
REQ-037 With macro MAP_SEQ_STATS_EN defined, the block SHALL add outputs n_data and n_pilot, each DEPHT_RAM+1 bits.
REQ-038 n_data and n_pilot SHALL clear on start, count accepted entries of type 01 and 10 respectively, saturate at all-ones, and hold their values after done.
REQ-039 Without MAP_SEQ_STATS_EN defined, those ports and counters SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-040 FFTSIZE=16, map with all codes 01, sc_ready=1, start with bw_sel=0 -> sc_idx 0..15 on consecutive cycles, first sc_valid 3 cycles after start, done at cycle 19, n_data=16.
REQ-041 Same setup with sc_ready toggling 1,0,0,1 repeatedly -> 16 entries, in order, no duplicates, outputs stable while stalled, exactly one done.
REQ-042 start with bw_sel=6 and NUM_BW=6 -> one err_bw pulse, busy stays 0, no sc_valid.
REQ-043 abort asserted at sc_idx=7 -> sc_valid=0 on the next cycle, no done, busy=0; a following start replays from index 0.
REQ-044 rst pulsed mid-RUN -> all outputs 0 asynchronously; after release, a start sequences the full symbol correctly.
REQ-045 Map holding pattern 00,01,10,11 with bw_sel=2 -> sc_type follows the profile-2 column, n_data=4, n_pilot=4 at FFTSIZE=16.
